haar_stage_evaluator: RTL

Consumes the per-word parameter stream of one Haar cascade stage from the stage database and produces the stage verdict for the current detection window. It sits directly downstream of the stage database reader and takes one 12-bit parameter word per accepted cycle. Per classifier it captures the node threshold and the left/right leaf values, and selects one leaf using an externally computed feature value. It then accumulates the selected leaves and compares the sum against the stage threshold carried in the trailing words of the stage record.

---
 rtl/haar_stage_evaluator.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/haar_stage_evaluator.sv
// Haar cascade stage evaluator: walks one stage record, selects a leaf per classifier and thresholds the sum.
// Optional stream-alignment checking is compiled in with `define HAAR_STAGE_ERROR_CHECK_EN.
module haar_stage_evaluator #(
    parameter int DATA_WIDTH_12            = 12,
    parameter int NUM_CLASSIFIERS_STAGE    = 10,
    parameter int NUM_PARAM_PER_CLASSIFIER = 19,
    parameter int NUM_STAGE_THRESHOLD      = 3,
    parameter int ACC_WIDTH                = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_valid,
    input  logic [DATA_WIDTH_12-1:0] i_data,
    input  logic                     i_end_database,
    input  logic [DATA_WIDTH_12-1:0] i_feature_value,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_pass,
    output logic [ACC_WIDTH-1:0]     o_sum,
    output logic [DATA_WIDTH_12-1:0] o_index_classifier,
    output logic                     o_error
);
    localparam int WORD_W = (NUM_PARAM_PER_CLASSIFIER > 1) ? $clog2(NUM_PARAM_PER_CLASSIFIER) : 1;
    localparam int THR_W  = (NUM_STAGE_THRESHOLD > 1) ? $clog2(NUM_STAGE_THRESHOLD) : 1;

    localparam logic [WORD_W-1:0]        W_NODE   = WORD_W'(NUM_PARAM_PER_CLASSIFIER - 3);
    localparam logic [WORD_W-1:0]        W_LEFT   = WORD_W'(NUM_PARAM_PER_CLASSIFIER - 2);
    localparam logic [WORD_W-1:0]        W_RIGHT  = WORD_W'(NUM_PARAM_PER_CLASSIFIER - 1);
    localparam logic [THR_W-1:0]         THR_LAST = THR_W'(NUM_STAGE_THRESHOLD - 1);
    localparam logic [DATA_WIDTH_12-1:0] CLS_LAST = DATA_WIDTH_12'(NUM_CLASSIFIERS_STAGE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLASSIFIER,
        S_STAGE_THR,
        S_RESULT
    } state_t;

    state_t                   state_reg;
    logic [WORD_W-1:0]        word_reg;
    logic [THR_W-1:0]         thr_cnt_reg;
    logic [DATA_WIDTH_12-1:0] node_thr_reg;
    logic [DATA_WIDTH_12-1:0] left_reg;
    logic [DATA_WIDTH_12-1:0] stage_thr_reg;
    logic [ACC_WIDTH-1:0]     acc_reg;

    // The right leaf is never stored: it is the word on the bus when the sum is updated.
    logic [DATA_WIDTH_12-1:0] leaf_sel;
    logic [ACC_WIDTH:0]       acc_wide;
    logic [ACC_WIDTH-1:0]     acc_sat;

    assign leaf_sel = (i_feature_value < node_thr_reg) ? left_reg : i_data;
    assign acc_wide = {1'b0, acc_reg} + (ACC_WIDTH + 1)'(leaf_sel);
    assign acc_sat  = acc_wide[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : acc_wide[ACC_WIDTH-1:0];
    assign o_busy   = (state_reg == S_CLASSIFIER) || (state_reg == S_STAGE_THR);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg          <= S_IDLE;
            word_reg           <= '0;
            thr_cnt_reg        <= '0;
            node_thr_reg       <= '0;
            left_reg           <= '0;
            stage_thr_reg      <= '0;
            acc_reg            <= '0;
            o_done             <= 1'b0;
            o_pass             <= 1'b0;
            o_sum              <= '0;
            o_index_classifier <= '0;
        end else begin
            o_done <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (i_valid) begin
                        state_reg          <= S_CLASSIFIER;
                        word_reg           <= WORD_W'(1);
                        acc_reg            <= '0;
                        o_index_classifier <= '0;
                    end
                end
                S_CLASSIFIER: begin
                    if (i_valid) begin
                        if (word_reg == W_NODE)
                            node_thr_reg <= i_data;
                        if (word_reg == W_LEFT)
                            left_reg <= i_data;
                        if (word_reg == W_RIGHT) begin
                            acc_reg            <= acc_sat;
                            word_reg           <= '0;
                            o_index_classifier <= o_index_classifier + DATA_WIDTH_12'(1);
                            if (o_index_classifier == CLS_LAST) begin
                                state_reg   <= S_STAGE_THR;
                                thr_cnt_reg <= '0;
                            end
                        end else begin
                            word_reg <= word_reg + WORD_W'(1);
                        end
                    end
                end
                S_STAGE_THR: begin
                    if (i_valid) begin
                        if (thr_cnt_reg == '0)
                            stage_thr_reg <= i_data;
                        if (thr_cnt_reg == THR_LAST)
                            state_reg <= S_RESULT;
                        else
                            thr_cnt_reg <= thr_cnt_reg + THR_W'(1);
                    end
                end
                S_RESULT: begin
                    o_done    <= 1'b1;
                    o_pass    <= (acc_reg >= ACC_WIDTH'(stage_thr_reg));
                    o_sum     <= acc_reg;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

`ifdef HAAR_STAGE_ERROR_CHECK_EN
    logic error_reg;
    logic final_word;

    // The end marker must coincide exactly with the last stage-threshold word.
    assign final_word = (state_reg == S_STAGE_THR) && (thr_cnt_reg == THR_LAST);

    always_ff @(posedge clk) begin
        if (!reset)
            error_reg <= 1'b0;
        else if (i_valid && (state_reg != S_RESULT) && (i_end_database != final_word))
            error_reg <= 1'b1;
    end

    assign o_error = error_reg;
`else
    logic unused_end_database;
    assign unused_end_database = i_end_database;
    assign o_error             = 1'b0;
`endif

endmodule
